taylor_pipe_engine: RTL and testbench
=====================================

// Module: taylor_pipe_engine
// PURPOSE
//  Parametrised N-stage pipelined polynomial/Taylor evaluator: y = sum_{k=0..n} c_k * x^k, fixed point.
//  One pipeline stage per term; x^k and partial sum are carried stage to stage; overflow is sticky.
//  Valid/ready streaming with global stall and a tag for ordering. Replaces the hand-chained single stages.
// PARAMETERS
//  N_STAGES  8   pipeline stages = maximum term count n (excluding c_0)
//  DW        32  data width of temp/coef/y (signed two's complement)
//  FRAC_W    30  fraction bits of DW values (1.0 = 1<<FRAC_W); range [-2^(DW-FRAC_W-1), +)
//  XW        8   width of x (unsigned Q0.XW, 0 <= x < 1)
//  TAG_W     4   width of passthrough tag
//  CW        $clog2(N_STAGES+1)  term-count width (derived, localparam)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active high
//  in_valid   in   1              input sample valid
//  in_ready   out  1              engine accepts sample this cycle
//  in_x       in   XW             x
//  in_terms   in   CW             n, number of terms after c_0 (values > N_STAGES clamp to N_STAGES)
//  in_tag     in   TAG_W          user tag, returned unchanged
//  coef_flat  in   (N_STAGES+1)*DW  c_k at [k*DW +: DW]; quasi-static, change only when drained
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  out_y      out  DW             result
//  out_ovf    out  1              overflow occurred anywhere for this sample
//  out_tag    out  TAG_W          tag of this result
// BEHAVIOUR
//  Reset: all stage valid bits, out_valid, out_y, out_ovf, out_tag = 0; in_ready = 1 the cycle after.
//  Stall = out_valid & ~out_ready; in_ready = ~stall; whole pipe freezes on stall (no bubbles collapse).
//  Accept when in_valid & in_ready: stage-0 input temp = 1.0, y = c_0, n = clamp(in_terms), ovf = 0.
//  Stage k (k=1..N_STAGES), if n_in != 0: temp' = fxmul(temp, x_q); y' = y + fxmul(temp', c_k); n' = n-1.
//   If n_in == 0: temp, y, n pass unchanged. x, tag, ovf pass along every stage.
//  x_q = in_x << (FRAC_W-XW); fxmul(a,b) = (a*b full 2DW signed) >>> FRAC_W, truncated to DW.
//  ovf' = ovf | product overflow (discarded high bits not sign extension) | add overflow
//   (operands same sign, sum sign differs).
//  Latency N_STAGES cycles accept->out_valid with no stall; throughput 1 sample/cycle.
//  Ordering strictly FIFO; out_tag matches in_tag of the same sample.
//  Simultaneous accept and output fire in the same cycle is legal and required at full rate.
//  rst mid-operation: all in-flight samples discarded, no stale out_valid afterwards.
//  in_terms = 0: out_y = c_0 exactly, out_ovf = 0.
// CONFIGURATION
//  TAYLOR_SAT_EN defined: on first overflow y clamps to max (0x7FFF..F) or min (0x800..0) by sign of
//   the true result and is held through remaining stages; out_ovf still = 1.
//  Not defined: y wraps (two's complement), out_ovf = 1, value unspecified beyond wrap arithmetic.
// STRUCTURE
//  taylor_pkg: FX_ONE, FX_MAX, FX_MIN constants, fxmul function with overflow flag, clamp helper.
//  Sub-module taylor_stage: one registered stage (temp, y, n, x, tag, ovf, valid) with enable = ~stall
//   and its coefficient; engine instantiates N_STAGES via generate and drives the output skid-free
//   from the last stage.
// TESTING (defaults, FRAC_W=30, 1.0 = 0x4000_0000)
//  All c_k = 1.0, x=0x80 (0.5), terms=3 -> out_y = 0x7800_0000 (1.875), ovf=0, after 8 cycles.
//  terms=0, c_0 = 0x1234_5678, any x -> out_y = 0x1234_5678, ovf=0.
//  All c_k = 1.0, x=0xFF, terms=8 -> ovf=1; with TAYLOR_SAT_EN out_y = 0x7FFF_FFFF.
//  Stream 16 samples tags 0..15, out_ready low cycles 5-9 -> no loss, tags in order, values match model.
//  3 samples in flight, rst 1 cycle -> next cycle out_valid=0, in_ready=1, none of the 3 emerge.
//  terms=12 (>8) -> identical to terms=8 result.

Source files
------------

// File: rtl/taylor_pkg.sv
// taylor_pkg: shared fixed-point constants, wide fxmul with overflow flag, term-count clamp
package taylor_pkg;
  localparam int MAX_W = 64;
  localparam int DEF_DW = 32;
  localparam int DEF_FRAC_W = 30;
  typedef logic signed [MAX_W-1:0] wide_t;
  typedef logic signed [2*MAX_W-1:0] wide2_t;
  function automatic wide_t fx_one(input int frac);
    return wide_t'(1) <<< frac;
  endfunction
  function automatic wide_t fx_max(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction
  function automatic wide_t fx_min(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction
  localparam wide_t FX_ONE = fx_one(DEF_FRAC_W);
  localparam wide_t FX_MAX = fx_max(DEF_DW);
  localparam wide_t FX_MIN = fx_min(DEF_DW);
  function automatic wide_t fxmul(input wide_t a, input wide_t b, input int dw, input int frac, output logic ovf);
    wide2_t p, r, t;
    p = wide2_t'(a) * wide2_t'(b);
    r = p >>> frac;
    t = (r <<< (2*MAX_W - dw)) >>> (2*MAX_W - dw);
    ovf = t != r;
    return wide_t'(t);
  endfunction
  function automatic int clamp_terms(input int t, input int hi);
    return t > hi ? hi : t;
  endfunction
endpackage

// File: rtl/taylor_pipe_engine_stage.sv
// taylor_stage: one registered Taylor term (TAYLOR_SAT_EN selects saturating y instead of wrap)
module taylor_stage import taylor_pkg::*; #(
  parameter int DW = 32,
  parameter int FRAC_W = 30,
  parameter int XW = 8,
  parameter int TAG_W = 4,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] coef,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_temp,
  input  logic signed [DW-1:0] in_y,
  input  logic [CW-1:0]        in_n,
  input  logic [XW-1:0]        in_x,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_ovf,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_temp,
  output logic signed [DW-1:0] out_y,
  output logic [CW-1:0]        out_n,
  output logic [XW-1:0]        out_x,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_ovf
);
  logic act, ov_t, ov_p, ov_a, ov_new;
  logic signed [DW-1:0] x_q, t_new, p, s, y_new;
`ifdef TAYLOR_SAT_EN
  localparam logic signed [DW-1:0] Y_MAX = DW'(fx_max(DW));
  localparam logic signed [DW-1:0] Y_MIN = DW'(fx_min(DW));
  logic neg;
`endif
  always_comb begin
    act = in_n != '0;
    x_q = DW'(in_x) << (FRAC_W - XW);
    t_new = DW'(fxmul(wide_t'(in_temp), wide_t'(x_q), DW, FRAC_W, ov_t));
    p = DW'(fxmul(wide_t'(t_new), wide_t'(coef), DW, FRAC_W, ov_p));
    s = in_y + p;
    ov_a = (in_y[DW-1] == p[DW-1]) && (s[DW-1] != in_y[DW-1]);
    ov_new = act & (ov_t | ov_p | ov_a);
`ifdef TAYLOR_SAT_EN
    neg = (ov_t | ov_p) ? in_temp[DW-1] ^ coef[DW-1] : in_y[DW-1];
    y_new = (!act || in_ovf) ? in_y : ov_new ? (neg ? Y_MIN : Y_MAX) : s;
`else
    y_new = act ? s : in_y;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_temp <= '0;
      out_y <= '0;
      out_n <= '0;
      out_x <= '0;
      out_tag <= '0;
      out_ovf <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_temp <= act ? t_new : in_temp;
      out_y <= y_new;
      out_n <= act ? in_n - CW'(1) : in_n;
      out_x <= in_x;
      out_tag <= in_tag;
      out_ovf <= in_ovf | ov_new;
    end
  end
endmodule

// File: rtl/taylor_pipe_engine.sv
// taylor_pipe_engine: N-stage pipelined fixed-point polynomial evaluator (TAYLOR_SAT_EN enables saturation)
module taylor_pipe_engine import taylor_pkg::*; #(
  parameter int N_STAGES = 8,
  parameter int DW = 32,
  parameter int FRAC_W = 30,
  parameter int XW = 8,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(N_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XW-1:0]            in_x,
  input  logic [CW-1:0]            in_terms,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [(N_STAGES+1)*DW-1:0] coef_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_y,
  output logic                     out_ovf,
  output logic [TAG_W-1:0]         out_tag
);
  logic v_a [N_STAGES+1];
  logic signed [DW-1:0] t_a [N_STAGES+1];
  logic signed [DW-1:0] y_a [N_STAGES+1];
  logic [CW-1:0] n_a [N_STAGES+1];
  logic [XW-1:0] x_a [N_STAGES+1];
  logic [TAG_W-1:0] g_a [N_STAGES+1];
  logic o_a [N_STAGES+1];
  logic en, unused_tail;
  assign en = ~(out_valid & ~out_ready);
  assign in_ready = en;
  assign v_a[0] = in_valid;
  assign t_a[0] = DW'(fx_one(FRAC_W));
  assign y_a[0] = coef_flat[0 +: DW];
  assign n_a[0] = CW'(clamp_terms(int'(in_terms), N_STAGES));
  assign x_a[0] = in_x;
  assign g_a[0] = in_tag;
  assign o_a[0] = 1'b0;
  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    taylor_stage #(.DW(DW), .FRAC_W(FRAC_W), .XW(XW), .TAG_W(TAG_W), .CW(CW)) u_stage (
      .clk(clk), .rst(rst), .en(en), .coef(coef_flat[(g+1)*DW +: DW]),
      .in_valid(v_a[g]), .in_temp(t_a[g]), .in_y(y_a[g]), .in_n(n_a[g]),
      .in_x(x_a[g]), .in_tag(g_a[g]), .in_ovf(o_a[g]),
      .out_valid(v_a[g+1]), .out_temp(t_a[g+1]), .out_y(y_a[g+1]), .out_n(n_a[g+1]),
      .out_x(x_a[g+1]), .out_tag(g_a[g+1]), .out_ovf(o_a[g+1])
    );
  end
  assign out_valid = v_a[N_STAGES];
  assign out_y = y_a[N_STAGES];
  assign out_ovf = o_a[N_STAGES];
  assign out_tag = g_a[N_STAGES];
  assign unused_tail = ^{t_a[N_STAGES], n_a[N_STAGES], x_a[N_STAGES]};
endmodule

// File: tb/tb_taylor_pipe_engine.sv
// tb_taylor_pipe_engine: directed vectors plus a plain-arithmetic scoreboard model of the Taylor engine
module tb_taylor_pipe_engine;
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] y;
    logic        ovf;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_ovf;
  logic [7:0] in_x = 0;
  logic [3:0] in_terms = 0, in_tag = 0, out_tag;
  logic [31:0] out_y;
  logic [287:0] coef_flat;
  logic signed [31:0] c [9];
  exp_t sb [$];
  int total = 0, bad = 0, n_out = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 9; g++) begin : g_coef
    assign coef_flat[g*32 +: 32] = c[g];
  end
  taylor_pipe_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_terms(in_terms), .in_tag(in_tag), .coef_flat(coef_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag)
  );
  function automatic bit fits(input longint v);
    return v >= -64'sd2147483648 && v <= 64'sd2147483647;
  endfunction
  function automatic longint wrap(input longint v);
    return longint'(int'(v));
  endfunction
  function automatic exp_t model(input logic [7:0] x, input int terms, input logic [3:0] tag);
    exp_t e;
    longint t, y, p, s, xq;
    int n;
    n = terms > 8 ? 8 : terms;
    t = 64'sd1073741824;
    y = longint'(c[0]);
    xq = longint'(x) * 64'sd4194304;
    e.ovf = 0;
    for (int k = 1; k <= n; k++) begin
      t = (t * xq) >>> 30;
      if (!fits(t)) begin e.ovf = 1; t = wrap(t); end
      p = (t * longint'(c[k])) >>> 30;
`ifdef TAYLOR_SAT_EN
      s = y + p;
      if (e.ovf || !fits(p) || !fits(s)) begin
        e.ovf = 1;
        y = s < 0 ? -64'sd2147483648 : 64'sd2147483647;
        break;
      end
      y = s;
`else
      if (!fits(p)) begin e.ovf = 1; p = wrap(p); end
      s = y + p;
      if (!fits(s)) begin e.ovf = 1; s = wrap(s); end
      y = s;
`endif
    end
    e.y = y[31:0];
    e.tag = tag;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back(model(in_x, int'(in_terms), in_tag));
  end
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("stale_out", 64'(out_valid), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", 64'(out_tag), 64'(e.tag));
        chk("sb_y", 64'(out_y), 64'(e.y));
        chk("sb_ovf", 64'(out_ovf), 64'(e.ovf));
        n_out++;
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] x, input int terms, input logic [3:0] tag);
    int w;
    in_valid = 1;
    in_x = x;
    in_terms = terms[3:0];
    in_tag = tag;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin w++; @(negedge clk); end
    if (w == 100) chk("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 0;
  endtask
  task automatic run_one(input string nm, input logic [7:0] x, input int terms,
                         input logic [31:0] ey, input logic eo);
    int lat;
    send(x, terms, 4'hA);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin lat++; @(negedge clk); end
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk({nm, "_y"}, 64'(out_y), 64'(ey));
    chk({nm, "_ovf"}, 64'(out_ovf), 64'(eo));
    chk({nm, "_tag"}, 64'(out_tag), 64'hA);
    tick();
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t m;
    int target, w, seen;
    for (int k = 0; k < 9; k++) c[k] = 32'sh4000_0000;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    m = model(8'h80, 3, 4'h0);
    chk("model_pin_half3", 64'(m.y), 64'h7800_0000);
    m = model(8'hFF, 8, 4'h0);
    chk("model_pin_ovf8", 64'(m.ovf), 64'd1);
    run_one("half3", 8'h80, 3, 32'h7800_0000, 1'b0);
    c[0] = 32'sh1234_5678;
    run_one("terms0", 8'h5A, 0, 32'h1234_5678, 1'b0);
    c[0] = 32'sh4000_0000;
`ifdef TAYLOR_SAT_EN
    run_one("ovf8", 8'hFF, 8, 32'h7FFF_FFFF, 1'b1);
`else
    m = model(8'hFF, 8, 4'h0);
    run_one("ovf8", 8'hFF, 8, m.y, 1'b1);
`endif
    for (int k = 1; k < 9; k++) c[k] = 32'sh0800_0000;
    m = model(8'hC0, 8, 4'h0);
    run_one("clamp12", 8'hC0, 12, m.y, m.ovf);
    c[0] = 32'sh2000_0000;
    c[1] = 32'shC000_0000;
    c[2] = 32'sh3000_0000;
    c[3] = -32'sh0123_4567;
    c[4] = 32'sh0765_4321;
    c[5] = 32'shE000_0000;
    c[6] = 32'sh3FFF_FFFF;
    c[7] = 32'sh8000_0000;
    c[8] = 32'sh0000_1234;
    target = n_out + 16;
    fork
      begin
        repeat (9) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
      begin
        for (int i = 0; i < 16; i++) send(8'(i * 17 + 3), i % 10, 4'(i));
      end
    join
    w = 0;
    while (n_out < target && w < 200) begin tick(); w++; end
    chk("stream_count", 64'(n_out), 64'(target));
    for (int i = 0; i < 3; i++) send(8'(40 + i), 5, 4'(i));
    rst = 1;
    sb.delete();
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_none", 64'(seen), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
